// File: rtl/core_pkg.sv
// Shared core types: fetch-stage widths and the fetch/decode hand-off entry.
// fetch_entry_t is also consumed by the decode stage.
package core_pkg;

  localparam int PC_WIDTH   = 11;
  localparam int ADDR_WIDTH = 24;
  localparam int INST_WIDTH = 16;
  localparam int NPC_WIDTH  = 16;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   npc;
  } fetch_entry_t;

  // Word-address increment; wraps modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch_entry_t with flush.
// Head is combinational from storage; pushes are never refused (caller holds credit).
module fetch_queue
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_dat_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  assign pop_eff = pop_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_eff})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited memory requests, one-deep in-flight tracking,
// prefetch queue to decode; redirect flushes everything and restarts at the target.
module fetch_unit #(
  parameter int PC_WIDTH   = core_pkg::PC_WIDTH,
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int INST_WIDTH = core_pkg::INST_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [INST_WIDTH-1:0] mem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [15:0]           if_npc
);

  import core_pkg::fetch_entry_t;

  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_npc_q, inflight_npc_d;
  logic                inflight_q, inflight_d;

  logic [CW-1:0]       q_count;
  logic [CW:0]         occupancy;
  fetch_entry_t        q_head;
  fetch_entry_t        q_push_dat;
  logic                q_push;
  logic                q_pop;
  logic                grant;

  // A slot is reserved for the in-flight word, so the queue can never overflow.
  assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
  assign mem_req   = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign grant     = mem_req && mem_gnt;
  assign mem_addr  = {{(ADDR_WIDTH-PC_WIDTH){1'b0}}, fetch_pc_q};

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    inflight_d     = inflight_q;
    inflight_npc_d = inflight_npc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
    end else if (grant) begin
      fetch_pc_d     = fetch_pc_q + PC_WIDTH'(1);
      inflight_d     = 1'b1;
      inflight_npc_d = fetch_pc_q + PC_WIDTH'(1);
    end else if (inflight_q) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q     <= '0;
      inflight_q     <= 1'b0;
      inflight_npc_q <= '0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_npc_q <= inflight_npc_d;
    end
  end

  // The word returning during a redirect belongs to the abandoned path.
  assign q_push          = inflight_q && !redirect_valid;
  assign q_pop           = if_valid && if_ready && !redirect_valid;
  assign q_push_dat.inst = mem_rdata;
  assign q_push_dat.npc  = inflight_npc_q;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid),
    .push_i    (q_push),
    .push_dat_i(q_push_dat),
    .pop_i     (q_pop),
    .head_o    (q_head),
    .count_o   (q_count)
  );

  assign if_valid = (q_count != '0);
  assign if_inst  = q_head.inst;
  assign if_npc   = {{(16-PC_WIDTH){1'b0}}, q_head.npc};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap, reset pulse.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [10:0] redirect_pc = 11'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_inst;
  logic [15:0] if_npc;

  int errors = 0;
  int checks = 0;
  int grants;
  int pops;
  logic [10:0] exp_npc;
  logic [10:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_inst       (if_inst),
    .if_npc        (if_npc)
  );

  // Odd multiplier makes every word address map to a distinct value.
  function automatic logic [15:0] memf(input logic [23:0] a);
    logic [23:0] t;
    t = a * 24'd40503 + 24'h001234;
    return t[15:0];
  endfunction

  // Memory: data is returned the cycle after a grant.
  always @(posedge clk) begin
    mem_rdata <= (mem_req && mem_gnt) ? memf(mem_addr) : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_inst", 32'(if_inst), 32'd0);
    chk("rst_if_npc", 32'(if_npc), 32'd0);

    // Free-running stream
    @(negedge clk);
    rst_n = 1'b1; mem_gnt = 1'b1; if_ready = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      chk("stream_req", 32'(mem_req), 32'd1);
      chk("stream_addr", 32'(mem_addr), 32'(k));
      chk("stream_valid", 32'(if_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("stream_npc", 32'(if_npc), 32'(k - 1));
        chk("stream_inst", 32'(if_inst), 32'(memf(24'(k - 2))));
      end
      @(negedge clk); #1;
    end

    // Backpressure: exactly DEPTH grants, then one more per pop
    rst_n = 1'b0; if_ready = 1'b0;
    #1;
    chk("bp_rst_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req && mem_gnt) grants++;
      @(negedge clk); #1;
    end
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_req_low", 32'(mem_req), 32'd0);
    chk("bp_valid", 32'(if_valid), 32'd1);
    chk("bp_head_npc", 32'(if_npc), 32'd1);
    chk("bp_head_inst", 32'(if_inst), 32'(memf(24'd0)));
    if_ready = 1'b1;
    #1;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_req && mem_gnt) begin
        grants++;
        chk("bp_refill_addr", 32'(mem_addr), 32'd4);
      end
      @(negedge clk);
      if_ready = 1'b0;
      #1;
    end
    chk("bp_refill_grants", 32'(grants), 32'd1);
    chk("bp_head_after_pop", 32'(if_npc), 32'd2);

    // Redirect with queue full and a simultaneous pop attempt
    redirect_valid = 1'b1; redirect_pc = 11'h050; if_ready = 1'b1;
    #1;
    chk("rdf_req_forced_low", 32'(mem_req), 32'd0);
    chk("rdf_valid_before", 32'(if_valid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rdf_valid_t1", 32'(if_valid), 32'd0);
    chk("rdf_req_t1", 32'(mem_req), 32'd1);
    chk("rdf_addr_t1", 32'(mem_addr), 32'h050);
    @(negedge clk); #1;
    chk("rdf_valid_t2", 32'(if_valid), 32'd0);
    chk("rdf_addr_t2", 32'(mem_addr), 32'h051);
    @(negedge clk); #1;
    chk("rdf_valid_t3", 32'(if_valid), 32'd1);
    chk("rdf_npc_t3", 32'(if_npc), 32'h051);
    chk("rdf_inst_t3", 32'(if_inst), 32'(memf(24'h050)));

    // Redirect while a response is returning
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 11'h123;
    #1;
    chk("rdr_req_forced_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rdr_addr_t1", 32'(mem_addr), 32'h123);
    chk("rdr_valid_t1", 32'(if_valid), 32'd0);
    @(negedge clk); #1;
    chk("rdr_valid_t2", 32'(if_valid), 32'd0);
    @(negedge clk); #1;
    chk("rdr_valid_t3", 32'(if_valid), 32'd1);
    chk("rdr_npc_t3", 32'(if_npc), 32'h124);
    chk("rdr_inst_t3", 32'(if_inst), 32'(memf(24'h123)));

    // PC wrap at 2047
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 11'd2046;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", 32'(mem_addr), 32'd2046);
    @(negedge clk); #1;
    chk("wrap_addr1", 32'(mem_addr), 32'd2047);
    @(negedge clk); #1;
    chk("wrap_addr2", 32'(mem_addr), 32'd0);
    chk("wrap_npc0", 32'(if_npc), 32'd2047);
    chk("wrap_inst0", 32'(if_inst), 32'(memf(24'd2046)));
    @(negedge clk); #1;
    chk("wrap_npc1", 32'(if_npc), 32'd0);
    chk("wrap_inst1", 32'(if_inst), 32'(memf(24'd2047)));
    @(negedge clk); #1;
    chk("wrap_npc2", 32'(if_npc), 32'd1);
    chk("wrap_inst2", 32'(if_inst), 32'(memf(24'd0)));

    // Random grants/ready with reset pulses at steps 0 and 150
    exp_npc = 11'd1;
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst_n    = !(i == 0 || i == 150);
      mem_gnt  = ($urandom_range(0, 1) == 1);
      if_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (i == 1 || i == 151) begin
        chk("rnd_post_rst_valid", 32'(if_valid), 32'd0);
        chk("rnd_post_rst_addr", 32'(mem_addr), 32'd0);
        chk("rnd_post_rst_req", 32'(mem_req), 32'd1);
        exp_npc = 11'd1;
      end
      if (rst_n && if_valid && if_ready) begin
        exp_pc = exp_npc - 11'd1;
        chk("rnd_pop_npc", 32'(if_npc), 32'(exp_npc));
        chk("rnd_pop_inst", 32'(if_inst), 32'(memf(24'(exp_pc))));
        exp_npc = exp_npc + 11'd1;
        pops++;
      end
    end
    chk("rnd_enough_pops", 32'(pops >= 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the five-stage pipelined core. It holds the 11-bit program counter and issues word reads on the core's shared memory port through the memory arbiter. Returned instruction words go into a small prefetch queue, and the queue presents instruction plus next-PC to the decode stage over a valid/ready handshake. A redirect from execute (taken branch or jump target) flushes the queue, discards any in-flight read, and restarts fetch at the target.

## Interface
Parameters:
- PC_WIDTH, 11, program counter width (word address)
- ADDR_WIDTH, 24, memory address width
- INST_WIDTH, 16, instruction/data word width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mem_req  out  1  read request to memory arbiter
- mem_addr  out  ADDR_WIDTH  read address = fetch PC zero-extended
- mem_gnt  in  1  arbiter accepted mem_req this cycle
- mem_rdata  in  INST_WIDTH  read data, valid the cycle after mem_gnt
- redirect_valid  in  1  execute requests PC change
- redirect_pc  in  PC_WIDTH  new fetch PC
- if_valid  out  1  queue head holds a valid instruction
- if_ready  in  1  decode accepts head this cycle
- if_inst  out  INST_WIDTH  head instruction
- if_npc  out  16  head PC+1, zero-extended

## Operation
- State: fetch_pc, inflight flag plus inflight_npc, queue storage, rd/wr pointers, count (0..DEPTH).
- Request rule: mem_req = rst_n && !redirect_valid && (count + inflight) < DEPTH. At most one read is in flight at a time, unless the in-flight read returns in the same cycle a new one is granted. Back-to-back grants therefore sustain 1 word/cycle.
- On mem_req && mem_gnt: inflight←1, inflight_npc←fetch_pc+1, fetch_pc←fetch_pc+1 (mod 2^PC_WIDTH; 2047 wraps to 0).
- Response: the cycle after a grant, mem_rdata and inflight_npc are pushed to the queue. inflight clears unless a new grant occurs in the same cycle.
- Pop: if_valid && if_ready advances rd pointer. A push and pop in the same cycle leaves count unchanged. A push is never refused, because the credit rule guarantees a free slot.
- if_valid = (count != 0). if_inst/if_npc are driven from the head entry and are don't-care when if_valid=0.
- Redirect (highest priority): fetch_pc←redirect_pc, count←0, pointers←0, inflight←0. The returning word of a read granted last cycle is dropped. A pop in the same cycle is ignored. mem_req is forced low that cycle.
- if_npc = {(16-PC_WIDTH)'b0, pc+1}.

## Timing
- Reset (rst_n low at edge): fetch_pc=0, count=0, inflight=0. Outputs: mem_req=0, mem_addr=0, if_valid=0, if_inst=0, if_npc=0 (queue storage cleared).
- First cycle after reset release: mem_req=1, mem_addr=0.
- Fetch latency, grant at cycle t: data at t+1, if_valid at t+2.
- Redirect at cycle t: mem_req=1 with mem_addr=redirect_pc at t+1. Earliest if_valid with that instruction is t+3.
- Reset asserted mid-operation: full clear at the next edge. Any in-flight response is discarded.
- Queue full (count=DEPTH), or count=DEPTH-1 with a read in flight: mem_req=0 until a pop.
- mem_gnt while mem_req=0 is ignored.

## Structure
- Shared package core_pkg:
  - PC_WIDTH, ADDR_WIDTH, INST_WIDTH constants.
  - fetch_entry_t typedef {inst, npc}, reused by decode.
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, head.
- fetch_unit holds the PC, request/credit logic, inflight tracking and redirect handling.

## Test plan
- Reset then free-running, mem_gnt=1 and if_ready=1 always: mem_addr 0,1,2,… every cycle. if_valid from cycle 2. if_npc 1,2,3,… with no gaps.
- if_ready=0, mem_gnt=1: exactly 4 grants occur. mem_req drops and stays 0, count=4. Raising if_ready for one cycle produces exactly one more request.
- Redirect to 0x123 in the same cycle a response returns: the returning word is not enqueued. mem_addr=0x123 the next cycle. The first popped if_npc is 0x124.
- Redirect with the queue full and if_ready=1 in the same cycle: the queue empties and the pop is ignored. if_valid=0 for two cycles.
- PC wrap: redirect to 2046. Successive mem_addr values are 2046, 2047, 0. if_npc values are 2047, 0, 1.
- mem_gnt toggling pseudo-randomly with rst_n pulsed low mid-stream: every popped instruction equals the memory model contents at if_npc-1, in order. After the reset pulse, if_valid=0 and the next mem_addr is 0.
